// File: rtl/jelly_mipi_tx_lane_dist_if.sv
// jelly_mipi_tx_lane_dist_if: packet byte stream from the packet builder to the lane distributor
interface jelly_mipi_tx_lane_dist_if #(
  parameter int LANES = 2
);
  logic [LANES*8-1:0] data;
  logic [LANES-1:0]   keep;
  logic               first;
  logic               last;
  logic               valid;
  logic               ready;
  modport master (output data, keep, first, last, valid, input ready);
  modport slave  (input data, keep, first, last, valid, output ready);
endinterface

// File: rtl/jelly_mipi_tx_lane_dist.sv
// jelly_mipi_tx_lane_dist: packet stream to per-lane D-PHY PPI HS transmit with sync, trailer and exit gap
module jelly_mipi_tx_lane_dist #(
  parameter int         LANES      = 2,
  parameter logic [7:0] SYNC_CODE  = 8'hB8,
  parameter int         TRAIL_LEN  = 2,
  parameter int         GAP_CYCLES = 8
) (
  input  logic                      reset,
  input  logic                      clk,
  jelly_mipi_tx_lane_dist_if.slave  s,
  output logic [LANES*8-1:0]        out_txdatahs,
  output logic [LANES-1:0]          out_txrequesths,
  input  logic                      in_txreadyhs,
  output logic                      busy,
  output logic                      err_underflow,
  output logic                      err_framing
);
  localparam int TW = $clog2(TRAIL_LEN + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, REQ, DATA, TRAIL, GAP} state_t;
  state_t                 state, state_next;
  logic [LANES-1:0][7:0]  last_byte, trail_byte, beat_byte, beat_last;
  logic [TW-1:0]          trail_cnt;
  logic [GW-1:0]          gap_cnt;
  logic                   start, frame_err, beat, under, trail, stop;
  // trailer is the inverse of the final serial bit (LSB first, so bit 7 goes out last)
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      trail_byte[i] = last_byte[i][7] ? 8'h00 : 8'hFF;
      beat_byte[i]  = s.keep[i] ? s.data[i*8 +: 8] : trail_byte[i];
      beat_last[i]  = s.keep[i] ? s.data[i*8 +: 8] : last_byte[i];
    end
  end
  always_comb begin
    state_next = state;
    s.ready    = 1'b0;
    start      = 1'b0;
    frame_err  = 1'b0;
    beat       = 1'b0;
    under      = 1'b0;
    trail      = 1'b0;
    stop       = 1'b0;
    case (state)
      IDLE: begin
        s.ready    = !s.first;
        start      = s.valid && s.first;
        frame_err  = s.valid && !s.first;
        state_next = start ? REQ : IDLE;
      end
      REQ, DATA: begin
        s.ready    = in_txreadyhs;
        beat       = in_txreadyhs && s.valid;
        under      = in_txreadyhs && !s.valid;
        state_next = (beat && s.last) ? TRAIL : in_txreadyhs ? DATA : state;
      end
      TRAIL: begin
        trail      = in_txreadyhs && trail_cnt != TW'(TRAIL_LEN);
        stop       = in_txreadyhs && trail_cnt == TW'(TRAIL_LEN);
        state_next = stop ? GAP : TRAIL;
      end
      GAP:     state_next = (gap_cnt == GW'(GAP_CYCLES - 1)) ? IDLE : GAP;
      default: state_next = IDLE;
    endcase
    if (reset) s.ready = 1'b0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_txdatahs    <= '0;
      out_txrequesths <= '0;
      last_byte       <= '0;
      trail_cnt       <= '0;
      gap_cnt         <= '0;
      err_underflow   <= 1'b0;
      err_framing     <= 1'b0;
    end else begin
      err_underflow <= under;
      err_framing   <= frame_err;
      if (start) begin
        out_txrequesths <= '1;
        out_txdatahs    <= {LANES{SYNC_CODE}};
        last_byte       <= {LANES{SYNC_CODE}};
      end
      if (beat) begin
        out_txdatahs <= beat_byte;
        last_byte    <= beat_last;
        trail_cnt    <= '0;
      end
      if (under) out_txdatahs <= '0;
      if (trail) begin
        out_txdatahs <= trail_byte;
        trail_cnt    <= trail_cnt + 1'b1;
      end
      if (stop) begin
        out_txrequesths <= '0;
        out_txdatahs    <= '0;
        gap_cnt         <= '0;
      end
      if (state == GAP) gap_cnt <= gap_cnt + 1'b1;
    end
  end
  assign busy = state != IDLE;
endmodule

// File: tb/tb_jelly_mipi_tx_lane_dist.sv
// tb_jelly_mipi_tx_lane_dist: randomized packets against a per-lane byte-stream model with a consumption scoreboard
module tb_jelly_mipi_tx_lane_dist;
  localparam int         L    = 2;
  localparam int         TL   = 2;
  localparam int         G    = 8;
  localparam logic [7:0] SYNC = 8'hB8;
  logic        clk = 0, reset = 1, rdy = 0;
  logic [15:0] txd;
  logic [1:0]  txreq;
  logic        busy, euf, efr;
  int          total = 0, bad = 0, exp_uf = 0, exp_fr = 0, uf_cnt = 0, fr_cnt = 0;
  bit          mon_en = 1, next_b2b = 0;
  logic [15:0] exp_q[$];
  logic [15:0] pd[4];
  jelly_mipi_tx_lane_dist_if #(.LANES(L)) sif();
  jelly_mipi_tx_lane_dist #(.LANES(L), .SYNC_CODE(SYNC), .TRAIL_LEN(TL), .GAP_CYCLES(G)) dut (
    .reset(reset), .clk(clk), .s(sif), .out_txdatahs(txd), .out_txrequesths(txreq),
    .in_txreadyhs(rdy), .busy(busy), .err_underflow(euf), .err_framing(efr));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", n, a, e);
    end
  endtask
  task automatic tick(input bit hi);
    @(posedge clk);
    #1;
    rdy = hi ? 1'b1 : ($urandom_range(0, 3) != 0);
  endtask
  task automatic idle(input int n);
    rdy = 1'b1;
    repeat (n) tick(1'b1);
  endtask
  task automatic put(input logic [15:0] d, input logic [1:0] k, input bit f, input bit l);
    bit hs = 0;
    int c = 0;
    sif.data = d; sif.keep = k; sif.first = f; sif.last = l; sif.valid = 1'b1;
    while (!hs && c < 300) begin
      @(negedge clk);
      hs = sif.ready;
      tick(1'b0);
      c++;
    end
    if (!hs) begin
      total++;
      bad++;
      $display("FAIL handshake_timeout got=none want=accept");
    end
  endtask
  // expected bytes come from the lane rules: sync, data or trailer for unkept lanes, then TL trailers
  task automatic send_pkt(input int n, input logic [15:0] d[4], input logic [1:0] kl, input int bub, input bit b2b);
    logic [1:0][7:0] lb, w;
    logic [15:0]     dw;
    bit              k;
    lb = {SYNC, SYNC};
    exp_q.push_back({SYNC, SYNC});
    for (int j = 0; j < n; j++) begin
      if (j == bub) begin
        exp_q.push_back(16'h0000);
        exp_uf++;
      end
      dw = d[j];
      for (int i = 0; i < L; i++) begin
        k = (j == n - 1) ? kl[i] : 1'b1;
        if (k) begin
          w[i]  = dw[i*8 +: 8];
          lb[i] = w[i];
        end else w[i] = lb[i][7] ? 8'h00 : 8'hFF;
      end
      exp_q.push_back(w);
    end
    repeat (TL) begin
      for (int i = 0; i < L; i++) w[i] = lb[i][7] ? 8'h00 : 8'hFF;
      exp_q.push_back(w);
    end
    if (!b2b) idle(40);
    next_b2b = b2b;
    for (int j = 0; j < n; j++) begin
      if (j == bub) begin
        sif.valid = 1'b0;
        rdy = 1'b1;
        tick(1'b0);
      end
      put(d[j], (j == n - 1) ? kl : 2'b11, j == 0, j == n - 1);
    end
    sif.valid = 1'b0;
  endtask
  initial begin
    bit          prev = 0, hadf = 0;
    int          lc = 0;
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (reset || !mon_en) begin
        prev = 0; hadf = 0; lc = 0;
      end else begin
        if (txreq[0] && rdy) begin
          chk("req_equal", txreq[1], txreq[0]);
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_byte got=%h want=none", txd);
          end else begin
            e = exp_q.pop_front();
            chk("lane_bytes", txd, e);
          end
        end
        if (euf) uf_cnt++;
        if (efr) fr_cnt++;
        if (prev && !txreq[0]) begin
          hadf = 1;
          lc = 0;
        end
        if (!txreq[0] && hadf) begin
          lc++;
          if (lc <= G) chk("gap_ready", sif.ready, 0);
          if (lc == G) chk("gap_busy", busy, 1);
          if (lc == G + 1) chk("idle_busy", busy, 0);
        end
        if (!prev && txreq[0] && hadf) begin
          if (next_b2b) chk("gap_len", lc, G + 1);
          else chk("gap_min", lc >= G + 1, 1);
        end
        prev = txreq[0];
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    sif.data = '0; sif.keep = '0; sif.first = 0; sif.last = 0; sif.valid = 0;
    #1;
    chk("rst_req", txreq, 0);
    chk("rst_data", txd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", sif.ready, 0);
    chk("rst_uf", euf, 0);
    chk("rst_fr", efr, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    pd = '{16'h1234, 16'h8001, 16'h0000, 16'h0000};
    send_pkt(2, pd, 2'b11, -1, 0);
    pd = '{16'h1234, 16'h5581, 16'h0000, 16'h0000};
    send_pkt(2, pd, 2'b01, -1, 1);
    pd = '{16'h1111, 16'h2222, 16'h3333, 16'h0000};
    send_pkt(3, pd, 2'b11, 1, 1);
    idle(40);
    sif.data = 16'h7E7E; sif.keep = 2'b11; sif.first = 0; sif.last = 0; sif.valid = 1;
    @(negedge clk);
    chk("fr_ready", sif.ready, 1);
    tick(1'b1);
    sif.valid = 0;
    exp_fr++;
    tick(1'b1);
    tick(1'b1);
    chk("fr_req", txreq, 0);
    idle(5);
    mon_en = 0;
    sif.data = 16'hA55A; sif.keep = 2'b11; sif.first = 1; sif.last = 0; sif.valid = 1;
    @(posedge clk);
    #1;
    sif.first = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_req", txreq, 2'b11);
    #2;
    reset = 1;
    #1;
    chk("async_rst_req", txreq, 0);
    chk("async_rst_data", txd, 0);
    chk("async_rst_ready", sif.ready, 0);
    chk("async_rst_busy", busy, 0);
    sif.valid = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    exp_q.delete();
    mon_en = 1;
    for (int p = 0; p < 30; p++) begin
      int n, bub;
      n = $urandom_range(1, 4);
      for (int j = 0; j < 4; j++) pd[j] = 16'($urandom);
      bub = (n > 1 && $urandom_range(0, 2) == 0) ? $urandom_range(1, n - 1) : -1;
      send_pkt(n, pd, $urandom_range(0, 1) ? 2'b01 : 2'b11, bub, (p == 0) ? 1'b0 : 1'($urandom_range(0, 1)));
    end
    idle(40);
    chk("queue_empty", exp_q.size(), 0);
    chk("underflow_count", uf_cnt, exp_uf);
    chk("framing_count", fr_cnt, exp_fr);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
